// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - borrow_in over WIDTH cycles.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready, a, b, borrow_in,
//   out_valid/out_ready, diff, borrow_out, busy.
// Optional port overflow (signed overflow) when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             overflow,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nx;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_bout;

  logic             w_accept;
  logic             w_last;
  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br_nx;
  logic [WIDTH-1:0] w_res_nx;

  assign w_a0     = r_a[0];
  assign w_b0     = r_b[0];
  assign w_d      = w_a0 ^ w_b0 ^ r_br;
  assign w_br_nx  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
  assign w_res_nx = {w_d, r_res[WIDTH-1:1]};
  assign w_last   = (r_cnt == LAST);
  assign w_accept = in_valid & in_ready;

  assign diff       = r_diff;
  assign borrow_out = r_bout;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nx;
  end

  always_comb begin
    w_nx      = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) w_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nx = IDLE;
      end
      default: w_nx = IDLE;
    endcase
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand signs are captured at accept because r_a/r_b shift away.
  logic r_sa;
  logic r_sb;
  logic r_ovf;

  assign overflow = r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_sa <= a[WIDTH-1];
      r_sb <= b[WIDTH-1];
    end else if (r_state == SHIFT && w_last) begin
      r_ovf <= (r_sa ^ r_sb) & (w_d ^ r_sa);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= borrow_in;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_br_nx;
      r_res <= w_res_nx;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff <= w_res_nx;
        r_bout <= w_br_nx;
      end
    end
  end

endmodule
